// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the round-robin APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_arb_state_e;

  // Index width that stays legal for a single-requester build.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NUM_REQ requesters with round-robin grants,
// sequencing SETUP/ACCESS and returning completion status to the owner.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_slverr,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_WIDTH/8-1:0]         PSTRB,
  input  logic [DATA_WIDTH-1:0]           PRDATA,
  input  logic                            PREADY,
  input  logic                            PSLVERR
);

  localparam int unsigned PW = idx_width(NUM_REQ);
  localparam int unsigned SW = DATA_WIDTH / 8;

  apb_arb_state_e            state;
  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             owner;
  logic                      arb_cycle;
  logic [NUM_REQ-1:0]        grant;
  logic [PW-1:0]             grant_idx;
  logic                      any_grant;
  logic                      sel_write;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]     sel_wdata;
  logic [SW-1:0]             sel_strb;

  assign arb_cycle = (state == ST_IDLE) || ((state == ST_ACCESS) && PREADY);
  assign any_grant = |grant;
  assign req_ready = grant;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_cycle),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_write = req_write[grant_idx];
    sel_addr  = req_addr [32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = req_wdata[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    sel_strb  = req_strb [32'(grant_idx) * SW +: SW];
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (state == ST_SETUP) begin
        PENABLE <= 1'b1;
        state   <= ST_ACCESS;
      end else if (arb_cycle) begin
        // Completion and the next grant share this cycle, so a back-to-back
        // transfer goes straight to SETUP with PSEL held high.
        if (state == ST_ACCESS) begin
          rsp_valid[owner] <= 1'b1;
          rsp_rdata        <= PWRITE ? '0 : PRDATA;
          rsp_slverr       <= PSLVERR;
        end
        PENABLE <= 1'b0;
        if (any_grant) begin
          state  <= ST_SETUP;
          PSEL   <= 1'b1;
          PWRITE <= sel_write;
          PADDR  <= sel_addr;
          PWDATA <= sel_wdata;
          PSTRB  <= sel_strb;
          owner  <= grant_idx;
          rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end else begin
          state <= ST_IDLE;
          PSEL  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (4-requester and 1-requester builds).
module tb_apb_master_arbiter;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [3:0]   req_valid, req_ready, req_write, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_strb;
  logic [31:0]  rsp_rdata, PADDR, PWDATA, PRDATA;
  logic         rsp_slverr, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]   PSTRB;

  logic         s_req_valid, s_req_ready, s_req_write, s_rsp_valid, s_rsp_slverr;
  logic [31:0]  s_req_addr, s_req_wdata, s_rsp_rdata, s_paddr, s_pwdata, s_prdata;
  logic [3:0]   s_req_strb, s_pstrb;
  logic         s_psel, s_penable, s_pwrite, s_pready, s_pslverr;

  int total = 0;
  int bad   = 0;

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_arbiter #(.NUM_REQ(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_strb(s_req_strb),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_slverr(s_rsp_slverr),
    .PSEL(s_psel), .PENABLE(s_penable), .PWRITE(s_pwrite), .PADDR(s_paddr),
    .PWDATA(s_pwdata), .PSTRB(s_pstrb), .PRDATA(s_prdata), .PREADY(s_pready), .PSLVERR(s_pslverr)
  );

  // Requesters must hold req_valid until accepted.
  logic [3:0] prev_valid = '0, prev_ready = '0;
  always @(posedge PCLK) begin
    for (int i = 0; i < 4; i++)
      if (!PRESET && prev_valid[i] && !prev_ready[i])
        assert (req_valid[i]) else $error("req_valid[%0d] dropped before req_ready", i);
    prev_valid <= req_valid;
    prev_ready <= req_ready;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[i]         = w;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]   = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    s_req_valid = 1'b0; s_req_write = 1'b0; s_req_addr = '0; s_req_wdata = '0;
    s_req_strb = '0; s_prdata = '0; s_pready = 1'b0; s_pslverr = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_psel", PSEL, 0);       check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);   check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);   check("rst_pstrb", PSTRB, 0);
    check("rst_rsp_valid", rsp_valid, 0); check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_slverr", rsp_slverr, 0); check("rst_req_ready", req_ready, 0);
    PRESET = 1'b0;
    tick();

    // 1: single write, zero wait states
    set_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    PREADY = 1'b1; PRDATA = 32'hFFFFFFFF;
    req_valid = 4'b0001; #1;
    check("t1_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    check("t1_setup_psel", PSEL, 1); check("t1_setup_pen", PENABLE, 0);
    check("t1_paddr", PADDR, 32'h100); check("t1_pwdata", PWDATA, 32'hDEADBEEF);
    check("t1_pwrite", PWRITE, 1); check("t1_pstrb", PSTRB, 4'hF);
    check("t1_ready_setup", req_ready, 0);
    tick();
    check("t1_access_psel", PSEL, 1); check("t1_access_pen", PENABLE, 1);
    check("t1_rsp_early", rsp_valid, 0);
    tick();
    check("t1_rsp_valid", rsp_valid, 4'b0001); check("t1_rdata", rsp_rdata, 0);
    check("t1_slverr", rsp_slverr, 0); check("t1_idle_psel", PSEL, 0);
    check("t1_idle_pen", PENABLE, 0);
    tick();
    check("t1_rsp_pulse", rsp_valid, 0); check("t1_paddr_hold", PADDR, 32'h100);

    // 2: read with three wait states
    set_req(1, 1'b0, 32'h200, 32'h0, 4'h3);
    PREADY = 1'b0;
    req_valid = 4'b0010; #1;
    check("t2_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    check("t2_setup_pen", PENABLE, 0); check("t2_pwrite", PWRITE, 0);
    check("t2_pstrb", PSTRB, 4'h3);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t2_wait_pen", PENABLE, 1); check("t2_wait_paddr", PADDR, 32'h200);
      check("t2_wait_rsp", rsp_valid, 0);
      tick();
    end
    check("t2_last_pen", PENABLE, 1);
    PREADY = 1'b1; PRDATA = 32'h12345678;
    tick();
    check("t2_rsp_valid", rsp_valid, 4'b0010); check("t2_rdata", rsp_rdata, 32'h12345678);
    check("t2_psel_idle", PSEL, 0);

    // 3: round-robin with all requesters active
    PRESET = 1'b1; tick(); PRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      set_req(i, iv[0], 32'h1000 + 32'(i*4), 32'hC0DE0000 + iv, 4'h1 << i);
    end
    PREADY = 1'b1; PRDATA = 32'h55;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      #1;
      check("t3_ready", req_ready, 4'b0001 << g);
      tick();
      if (k >= 1) req_valid[g] = 1'b0;
      check("t3_setup_psel", PSEL, 1); check("t3_setup_pen", PENABLE, 0);
      check("t3_paddr", PADDR, 32'h1000 + 32'(g*4));
      check("t3_rsp", rsp_valid, (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4)));
      tick();
      check("t3_access_psel", PSEL, 1); check("t3_access_pen", PENABLE, 1);
    end
    #1;
    check("t3_ready_none", req_ready, 0);
    tick();
    check("t3_last_rsp", rsp_valid, 4'b0001); check("t3_last_rdata", rsp_rdata, 32'h55);
    check("t3_idle_psel", PSEL, 0);

    // 4: slave error then clean transfer
    set_req(2, 1'b1, 32'h2A0, 32'h0BADF00D, 4'hC);
    PSLVERR = 1'b1;
    req_valid = 4'b0100; #1;
    check("t4_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    tick(); tick();
    check("t4_rsp_valid", rsp_valid, 4'b0100); check("t4_slverr", rsp_slverr, 1);
    check("t4_rdata", rsp_rdata, 0);
    set_req(3, 1'b0, 32'h3A0, 32'h0, 4'h1);
    PSLVERR = 1'b0; PRDATA = 32'hA5A50003;
    req_valid = 4'b1000; #1;
    check("t4b_ready", req_ready, 4'b1000);
    tick(); req_valid = '0;
    check("t4b_slverr_hold", rsp_slverr, 1); check("t4b_rsp_none", rsp_valid, 0);
    tick(); tick();
    check("t4b_rsp_valid", rsp_valid, 4'b1000); check("t4b_slverr", rsp_slverr, 0);
    check("t4b_rdata", rsp_rdata, 32'hA5A50003);

    // 5: reset during a stalled ACCESS
    set_req(1, 1'b0, 32'h1B0, 32'h0, 4'h2);
    PREADY = 1'b0;
    req_valid = 4'b0010; #1;
    check("t5_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    tick();
    check("t5_access_pen", PENABLE, 1);
    PRESET = 1'b1;
    tick(); PRESET = 1'b0;
    check("t5_psel", PSEL, 0); check("t5_pen", PENABLE, 0);
    check("t5_rsp", rsp_valid, 0); check("t5_paddr", PADDR, 0);
    check("t5_rr_ptr", u_dut.rr_ptr, 0);
    PREADY = 1'b1;
    tick();
    check("t5_no_late_rsp", rsp_valid, 0);
    set_req(3, 1'b0, 32'h300, 32'h0, 4'hF);
    PRDATA = 32'h00000300;
    req_valid = 4'b1000; #1;
    check("t5_req3_ready", req_ready, 4'b1000);
    tick(); req_valid = '0;
    check("t5_req3_psel", PSEL, 1); check("t5_req3_paddr", PADDR, 32'h300);
    tick(); tick();
    check("t5_req3_rsp", rsp_valid, 4'b1000); check("t5_req3_rdata", rsp_rdata, 32'h300);
    check("t5_ptr_wrap", u_dut.rr_ptr, 0);

    // 6: single-requester build, back-to-back reads
    s_req_write = 1'b0; s_req_addr = 32'h40; s_req_strb = 4'h5;
    s_pready = 1'b1;
    s_req_valid = 1'b1; #1;
    check("t6_ready", s_req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) s_req_valid = 1'b0;
      check("t6_setup_psel", s_psel, 1); check("t6_setup_pen", s_penable, 0);
      check("t6_rr_ptr", u_dut1.rr_ptr, 0);
      check("t6_rsp", s_rsp_valid, (k > 0) ? 1 : 0);
      if (k > 0) check("t6_rdata", s_rsp_rdata, 32'h100 + 32'(k - 1));
      tick();
      s_prdata = 32'h100 + 32'(k);
      check("t6_access_pen", s_penable, 1);
      check("t6_access_ready", s_req_ready, (k < 2) ? 1 : 0);
    end
    tick();
    check("t6_last_rsp", s_rsp_valid, 1); check("t6_last_rdata", s_rsp_rdata, 32'h102);
    check("t6_idle_psel", s_psel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
